tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
Parametrised, registered 1-to-N time-division demultiplexer for the time-domain RF datapath. It routes a DATA_W-bit sample stream to one of N_CH channel registers. The channel is chosen either by an explicit select or by an internal round-robin slot counter that recovers interleaved channels from a TDM stream. Each channel carries a valid strobe, and the block flags frame boundaries and select errors.

Parameters:
N_CH, 8, number of output channels (2..64; need not be a power of two)
DATA_W, 8, sample width in bits
HOLD, 1, 1 = unselected channels hold their last value; 0 = unselected channels are zeroed every cycle
SEL_W, $clog2(N_CH), localparam, select/slot counter width

Ports:
clk_i  in  1  sole clock
rst_ni  in  1  reset; asynchronous, active-low
data_i  in  DATA_W  input sample
valid_i  in  1  data_i is valid this cycle
sel_i  in  SEL_W  channel select (manual mode only)
mode_i  in  1  0 = manual (sel_i), 1 = auto round-robin
sync_i  in  1  force slot counter to 0 (auto mode)
data_o  out  N_CH x DATA_W  per-channel registered samples
valid_o  out  N_CH  one-cycle strobe per channel written
frame_o  out  1  one-cycle pulse when slot N_CH-1 is written in auto mode
slot_o  out  SEL_W  current slot counter value
err_o  out  1  sticky out-of-range select flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. clk_i and rst_ni.
- Reset values: data_o all 0, valid_o 0, frame_o 0, slot_o 0, err_o 0. Asserting reset mid-frame discards state immediately.
- Latency: a sample accepted on cycle t appears on data_o[ch] with valid_o[ch]=1 at t+1. Throughput is one sample per cycle. There is no backpressure.
- Effective channel ch:
  - Manual mode: ch = sel_i.
  - Auto mode: ch = 0 if sync_i=1, otherwise ch = the slot counter.
- On valid_i=1 with ch < N_CH:
  - data_o[ch] <= data_i and valid_o[ch] <= 1.
  - Other valid_o bits are 0.
  - Other data_o entries hold if HOLD=1, or go to 0 if HOLD=0.
- On valid_i=0:
  - valid_o is all 0.
  - data_o holds if HOLD=1, or is all 0 if HOLD=0.
- Slot counter, auto mode:
  - Advances by one per accepted sample.
  - Wraps explicitly from N_CH-1 to 0; no reliance on power-of-two overflow.
  - sync_i=1 without valid_i sets the counter to 0.
  - sync_i=1 with valid_i=1 writes channel 0 and sets the counter to 1 (to 0 if N_CH=1 is ever allowed; the minimum is 2).
- Slot counter, manual mode: holds its value.
- Mode changes:
  - Any change of mode_i (registered edge detect) resets the counter to 0 on the following cycle.
  - The sample in the change cycle uses the new mode_i value.
- frame_o: pulses 1 at t+1 when auto mode writes channel N_CH-1. It is never asserted in manual mode.
- Out-of-range select:
  - Applies in manual mode with sel_i >= N_CH and valid_i=1 (possible only when N_CH is not a power of two).
  - The sample is dropped, no valid_o bit is set, and data_o follows the valid_i=0 rule.
  - err_o is set and stays set until reset.
- sel_i is ignored in auto mode. sync_i is ignored in manual mode.
- slot_o is a registered copy of the counter.

Decomposition:
- Shared package tdm_pkg holds:
  - mode enum tdm_mode_e (TDM_MANUAL=0, TDM_AUTO=1)
  - default constants TDM_N_CH=8 and TDM_DATA_W=8
- One sub-module, tdm_slot_ctr: modulo-N_CH counter with sync, advance enable and mode-change clear. Its outputs are slot and wrap.
- Channel registers and decode live in tdm_demux using a generate loop.

Test Plan:
1. Reset: hold rst_ni=0 with random inputs -> all outputs 0. Release, drive valid_i=0 -> outputs stay 0.
2. Manual mode, N_CH=8, HOLD=1: drive sel_i=3, data_i=0xA5, valid_i=1 for one cycle, then sel_i=5, data_i=0x3C -> data_o[3]=0xA5 with valid_o=8'b0000_1000, then data_o[5]=0x3C with valid_o=8'b0010_0000. data_o[3] still reads 0xA5.
3. Auto mode, 8 consecutive valid samples 0x10..0x17 -> data_o[i]=0x10+i. frame_o pulses exactly once, in the cycle after the 8th sample. slot_o wraps to 0.
4. Auto mode: after 3 samples, assert sync_i with valid_i and data_i=0xFF -> data_o[0]=0xFF, slot_o=1. A gap cycle with valid_i=0 leaves the counter unchanged.
5. N_CH=6, manual mode: sel_i=7, valid_i=1 -> no valid_o bit set, data_o unchanged, err_o=1 and sticky. Then sel_i=2 -> normal write, err_o remains 1.
6. HOLD=0 and reset mid-frame: write channel 1 = 0x55, then idle one cycle -> data_o[1]=0 on the idle cycle. In auto mode at slot 4, pulse rst_ni low asynchronously -> immediate all-zero outputs and slot_o=0.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared mode encoding and default sizing for the TDM demultiplexer
package tdm_pkg;
  typedef enum logic {TDM_MANUAL = 1'b0, TDM_AUTO = 1'b1} tdm_mode_e;
  localparam int TDM_N_CH = 8;
  localparam int TDM_DATA_W = 8;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: modulo-N_CH slot counter with sync, advance and mode-change clear
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv,
  input  logic             sync,
  input  logic             clr,
  output logic [SEL_W-1:0] slot,
  output logic             wrap
);
  logic [SEL_W-1:0] nxt;
  logic             last;
  // next slot: clear beats sync, sync with a sample lands on 1, explicit wrap at N_CH-1
  always_comb begin
    last = slot == SEL_W'(N_CH - 1);
    nxt  = clr ? '0 : sync ? (adv ? SEL_W'(1) : '0) : !adv ? slot : last ? '0 : slot + SEL_W'(1);
  end
  assign wrap = adv && !sync && last;
  // slot register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) slot <= '0;
    else slot <= nxt;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: registered 1-to-N time-division demultiplexer with manual or round-robin channel select
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH,
  parameter int DATA_W = TDM_DATA_W,
  parameter int HOLD = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         valid_i,
  input  logic [SEL_W-1:0]             sel_i,
  input  logic                         mode_i,
  input  logic                         sync_i,
  output logic [N_CH-1:0][DATA_W-1:0]  data_o,
  output logic [N_CH-1:0]              valid_o,
  output logic                         frame_o,
  output logic [SEL_W-1:0]             slot_o,
  output logic                         err_o
);
  tdm_mode_e        mode, mode_q;
  logic             is_auto, in_range, wr, wrap;
  logic [SEL_W-1:0] slot, ch;
  // effective channel: sync forces slot 0 in auto mode; out-of-range selects are only reachable manually
  always_comb begin
    mode     = tdm_mode_e'(mode_i);
    is_auto  = mode == TDM_AUTO;
    ch       = is_auto ? (sync_i ? '0 : slot) : sel_i;
    in_range = {1'b0, ch} < (SEL_W + 1)'(N_CH);
    wr       = valid_i && in_range;
  end
  tdm_slot_ctr #(.N_CH(N_CH), .SEL_W(SEL_W)) u_ctr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .adv   (is_auto && valid_i),
    .sync  (is_auto && sync_i),
    .clr   (mode != mode_q),
    .slot  (slot),
    .wrap  (wrap)
  );
  assign slot_o = slot;
  // mode edge detect, frame pulse and sticky select error
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mode_q  <= TDM_MANUAL;
      frame_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      mode_q  <= mode;
      frame_o <= wrap;
      err_o   <= err_o || (valid_i && !in_range);
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // channel register: load on a hit, otherwise hold or clear
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        data_o[i]  <= '0;
        valid_o[i] <= 1'b0;
      end else begin
        data_o[i]  <= (wr && ch == SEL_W'(i)) ? data_i : (HOLD != 0) ? data_o[i] : '0;
        valid_o[i] <= wr && ch == SEL_W'(i);
      end
  end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: randomized and directed check of three tdm_demux configurations against a behavioural model
module tb_tdm_demux;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       vin = 1'b0, min = 1'b0, syn = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0][7:0] d_a, d_c;
  logic [5:0][7:0] d_b;
  logic [7:0] v_a, v_c;
  logic [5:0] v_b;
  logic       f_a, f_b, f_c, e_a, e_b, e_c;
  logic [2:0] s_a, s_b, s_c;
  int total = 0, passed = 0;
  int n_of[3] = '{8, 6, 8};
  bit hold_of[3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] md[3][64];
  logic [63:0] mv[3];
  logic mf[3], me[3], mpm[3];
  int ms[3];
  always #5 clk = ~clk;
  tdm_demux #(.N_CH(8), .DATA_W(8), .HOLD(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din), .valid_i(vin), .sel_i(sel), .mode_i(min), .sync_i(syn),
    .data_o(d_a), .valid_o(v_a), .frame_o(f_a), .slot_o(s_a), .err_o(e_a));
  tdm_demux #(.N_CH(6), .DATA_W(8), .HOLD(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din), .valid_i(vin), .sel_i(sel), .mode_i(min), .sync_i(syn),
    .data_o(d_b), .valid_o(v_b), .frame_o(f_b), .slot_o(s_b), .err_o(e_b));
  tdm_demux #(.N_CH(8), .DATA_W(8), .HOLD(0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .data_i(din), .valid_i(vin), .sel_i(sel), .mode_i(min), .sync_i(syn),
    .data_o(d_c), .valid_o(v_c), .frame_o(f_c), .slot_o(s_c), .err_o(e_c));
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 64; c++) md[k][c] = '0;
      mv[k] = '0; mf[k] = 1'b0; me[k] = 1'b0; mpm[k] = 1'b0; ms[k] = 0;
    end
  endtask
  task automatic model_step(input logic [7:0] d, input logic v, input logic [2:0] s, input logic m, input logic sy);
    for (int k = 0; k < 3; k++) begin
      int n = n_of[k];
      int ch = m ? (sy ? 0 : ms[k]) : int'(s);
      bit w = v && ch < n;
      for (int c = 0; c < n; c++)
        if (w && c == ch) md[k][c] = d;
        else if (!hold_of[k]) md[k][c] = '0;
      mv[k] = w ? (64'd1 << ch) : 64'd0;
      mf[k] = m && w && ch == n - 1;
      if (!m && v && ch >= n) me[k] = 1'b1;
      if (m != mpm[k]) ms[k] = 0;
      else if (m && sy) ms[k] = v ? 1 : 0;
      else if (m && v) ms[k] = (ms[k] + 1) % n;
      mpm[k] = m;
    end
  endtask
  task automatic chk(input string tag, input int k, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d] got %0h expected %0h", tag, k, obs, exp);
  endtask
  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [511:0] ed = '0;
      for (int c = 0; c < n_of[k]; c++) ed[c*8 +: 8] = md[k][c];
      chk("data", k, k == 0 ? 512'(d_a) : k == 1 ? 512'(d_b) : 512'(d_c), ed);
      chk("valid", k, k == 0 ? 512'(v_a) : k == 1 ? 512'(v_b) : 512'(v_c), 512'(mv[k]));
      chk("frame", k, k == 0 ? 512'(f_a) : k == 1 ? 512'(f_b) : 512'(f_c), 512'(mf[k]));
      chk("slot", k, k == 0 ? 512'(s_a) : k == 1 ? 512'(s_b) : 512'(s_c), 512'(ms[k]));
      chk("err", k, k == 0 ? 512'(e_a) : k == 1 ? 512'(e_b) : 512'(e_c), 512'(me[k]));
    end
  endtask
  task automatic cyc(input logic [7:0] d, input logic v, input logic [2:0] s, input logic m, input logic sy);
    @(negedge clk);
    din = d; vin = v; sel = s; min = m; syn = sy;
    @(posedge clk);
    model_step(d, v, s, m, sy);
    #1 check_all();
  endtask
  task automatic rand_inputs();
    din = 8'($urandom); vin = 1'($urandom); sel = 3'($urandom); min = 1'($urandom); syn = 1'($urandom);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rand_inputs();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1; din = '0; vin = 1'b0; sel = '0; min = 1'b0; syn = 1'b0;
  endtask
  initial begin
    logic m_cur = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) rand_inputs();
      @(posedge clk);
      #1 check_all();
    end
    @(negedge clk);
    rst_n = 1'b1; din = '0; vin = 1'b0; sel = '0; min = 1'b0; syn = 1'b0;
    cyc(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(8'hA5, 1'b1, 3'd3, 1'b0, 1'b0);
    cyc(8'h3C, 1'b1, 3'd5, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(8'(8'h10 + i), 1'b1, 3'(i), 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(8'(8'h20 + i), 1'b1, 3'd0, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 3'd6, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    cyc(8'h77, 1'b1, 3'd0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(8'h9E, 1'b1, 3'd7, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(8'h42, 1'b1, 3'd2, 1'b0, 1'b0);
    cyc(8'h55, 1'b1, 3'd1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 3'd1, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(8'(8'h60 + i), 1'b1, 3'd0, 1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) m_cur = ~m_cur;
      cyc(8'($urandom), $urandom_range(3) != 0, 3'($urandom), m_cur, $urandom_range(7) == 0);
      if (i == 200) begin
        async_reset();
        m_cur = 1'b0;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
